// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers; optional madd/msub under MDU_MADD_EN.
// Latency: MULT_CYCLES (mult/madd) or DIV_CYCLES (div) edges after Start; HI/LO update as Busy falls.
// Backpressure: none; Busy stalls the hazard unit, and Start/HIWrite/LOWrite are ignored while Busy.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDUOp,
  input  logic             Acc,
  input  logic             Sub,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] res;
  logic               wr;

  logic               is_div, sgn, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, uq, ur, dq, dr;
  logic [2*WIDTH-1:0] prod, res_c, fin;

  // Signed divide works on magnitudes, then restores signs; MIN/-1 wraps back to MIN naturally.
  always_comb begin
    is_div = MDUOp[1];
    sgn    = MDUOp[0];
    b_zero = (B == '0);
    prod   = sgn ? ({{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B})
                 : ({{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B});
    abs_a  = (sgn && A[WIDTH-1]) ? -A : A;
    abs_b  = (sgn && B[WIDTH-1]) ? -B : B;
    uq     = b_zero ? '0 : abs_a / abs_b;
    ur     = b_zero ? '0 : abs_a % abs_b;
    dq     = (sgn && (A[WIDTH-1] ^ B[WIDTH-1])) ? -uq : uq;
    dr     = (sgn && A[WIDTH-1]) ? -ur : ur;
    res_c  = is_div ? {dr, dq} : prod;
  end

`ifdef MDU_MADD_EN
  logic acc_q, sub_q;

  // Accumulation reads HI/LO at completion, so a preceding mthi/mtlo is always honoured.
  always_comb begin
    fin = res;
    if (acc_q) fin = sub_q ? ({HI, LO} - res) : ({HI, LO} + res);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= 1'b0;
      sub_q <= 1'b0;
    end else if (state == IDLE && Start && !Flush) begin
      acc_q <= Acc && !MDUOp[1];
      sub_q <= Sub;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = ^{Acc, Sub};

  always_comb fin = res;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      wr    <= 1'b0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            res   <= res_c;
            wr    <= !(is_div && b_zero);
            cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state <= RUN;
            Busy  <= 1'b1;
          end else if (!Flush) begin
            if (HIWrite) HI <= A;
            if (LOWrite) LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (wr) {HI, LO} <= fin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: cycle-level reference model plus literal expectations.
module tb_mdu_seq;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start, Acc, Sub, HIWrite, LOWrite, Flush;
  logic [1:0]   MDUOp;
  logic [W-1:0] A, B;
  logic         Busy;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .Acc(Acc), .Sub(Sub),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .Flush(Flush), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Arithmetic meaning of each op as {HI,LO}, from plain integer operators.
  function automatic logic [63:0] compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      2'b00: return ua * ub;
      2'b01: return 64'(sa * sb);
      2'b10: return (b == 0) ? 64'b0 : {a % b, a / b};
      default: begin
        if (b == 0) return 64'b0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
    endcase
  endfunction

  // Reference model: remaining-busy countdown and pending result.
  logic [W-1:0] m_hi, m_lo;
  int           m_rem;
  logic [63:0]  m_res;
  logic         m_wr, m_acc, m_sub;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi  <= '0;
      m_lo  <= '0;
      m_rem <= 0;
      m_res <= '0;
      m_wr  <= 1'b0;
      m_acc <= 1'b0;
      m_sub <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) begin
        if (m_acc) {m_hi, m_lo} <= m_sub ? ({m_hi, m_lo} - m_res) : ({m_hi, m_lo} + m_res);
        else       {m_hi, m_lo} <= m_res;
      end
    end else if (Start && !Flush) begin
      m_rem <= MDUOp[1] ? DC : MC;
      m_res <= compute(MDUOp, A, B);
      m_wr  <= !(MDUOp[1] && B == 0);
`ifdef MDU_MADD_EN
      m_acc <= Acc && !MDUOp[1];
      m_sub <= Sub;
`else
      m_acc <= 1'b0;
      m_sub <= 1'b0;
`endif
    end else if (!Flush) begin
      if (HIWrite) m_hi <= A;
      if (LOWrite) m_lo <= A;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("model_busy", 64'(Busy), 64'(m_rem > 0));
      chk("model_hi", 64'(HI), 64'(m_hi));
      chk("model_lo", 64'(LO), 64'(m_lo));
    end
  end

  task automatic idle_inputs();
    Start = 0; Acc = 0; Sub = 0; HIWrite = 0; LOWrite = 0; Flush = 0; MDUOp = 2'b00;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic acc, input logic sub, input int exp_cyc);
    int cyc;
    @(posedge clk); #1;
    Start = 1; MDUOp = op; A = a; B = b; Acc = acc; Sub = sub;
    @(posedge clk); #1;
    idle_inputs();
    A = ~a; B = ~b;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk({nm, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic mtx(input logic hw, input logic lw, input logic [31:0] v);
    @(posedge clk); #1;
    HIWrite = hw; LOWrite = lw; A = v;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    A = '0; B = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_hi", 64'(HI), 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("mult_neg2x3", 2'b01, 32'hFFFF_FFFE, 32'd3, 0, 0, 5);
    chk("mult_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(LO), 64'hFFFF_FFFA);

    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 0, 10);
    chk("divu_hi", 64'(HI), 64'd2);
    chk("divu_lo", 64'(LO), 64'd14);

    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 10);
    chk("div_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("div_lo", 64'(LO), 64'hFFFF_FFFD);

    mtx(1, 0, 32'h1234);
    mtx(0, 1, 32'h5678);
    run_op("div_by0", 2'b11, 32'd55, 32'd0, 0, 0, 10);
    chk("div0_hi", 64'(HI), 64'h1234);
    chk("div0_lo", 64'(LO), 64'h5678);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5);
    chk("multu_hi", 64'(HI), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(LO), 64'h0000_0001);

    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 10);
    chk("divmin_hi", 64'(HI), 64'h0);
    chk("divmin_lo", 64'(LO), 64'h8000_0000);

    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 0, 0, 10);
    chk("div7_hi", 64'(HI), 64'h1);
    chk("div7_lo", 64'(LO), 64'hFFFF_FFFD);

    // Flush masks Start and the HI/LO writes of the same cycle.
    @(posedge clk); #1;
    Start = 1; Flush = 1; HIWrite = 1; LOWrite = 1; MDUOp = 2'b01; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    idle_inputs();
    chk("flush_busy", 64'(Busy), 64'd0);
    chk("flush_hi", 64'(HI), 64'h1);
    chk("flush_lo", 64'(LO), 64'hFFFF_FFFD);

    // Start wins over a simultaneous mthi.
    @(posedge clk); #1;
    Start = 1; HIWrite = 1; MDUOp = 2'b01; A = 32'd2; B = 32'd3;
    @(posedge clk); #1;
    idle_inputs();
    repeat (6) @(posedge clk);
    #1;
    chk("startwin_hi", 64'(HI), 64'h0);
    chk("startwin_lo", 64'(LO), 64'h6);

    mtx(1, 1, 32'hAA);
    chk("both_hi", 64'(HI), 64'hAA);
    chk("both_lo", 64'(LO), 64'hAA);

    // mthi/mtlo while running are ignored; operands already captured.
    @(posedge clk); #1;
    Start = 1; MDUOp = 2'b00; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    idle_inputs();
    HIWrite = 1; LOWrite = 1; A = 32'hDEAD; B = 32'h7;
    @(posedge clk); #1;
    idle_inputs();
    repeat (5) @(posedge clk);
    #1;
    chk("runwr_busy", 64'(Busy), 64'd0);
    chk("runwr_hi", 64'(HI), 64'h0);
    chk("runwr_lo", 64'(LO), 64'h1);

    // Reset in the middle of a mult.
    @(posedge clk); #1;
    Start = 1; MDUOp = 2'b01; A = 32'd5; B = 32'd5;
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_hi", 64'(HI), 64'd0);
    chk("midrst_lo", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef MDU_MADD_EN
    mtx(1, 1, 32'h0);
    mtx(0, 1, 32'hFFFF_FFFF);
    run_op("maddu", 2'b00, 32'd1, 32'd1, 1, 0, 5);
    chk("maddu_hi", 64'(HI), 64'h1);
    chk("maddu_lo", 64'(LO), 64'h0);
    run_op("msub", 2'b01, 32'd1, 32'd2, 1, 1, 5);
    chk("msub_hi", 64'(HI), 64'h0);
    chk("msub_lo", 64'(LO), 64'hFFFF_FFFE);
    run_op("acc_div", 2'b10, 32'd9, 32'd4, 1, 0, 10);
    chk("accdiv_hi", 64'(HI), 64'h1);
    chk("accdiv_lo", 64'(LO), 64'h2);
`else
    mtx(1, 1, 32'h77);
    run_op("acc_ignored", 2'b01, 32'd2, 32'd3, 1, 1, 5);
    chk("accign_hi", 64'(HI), 64'h0);
    chk("accign_lo", 64'(LO), 64'h6);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the EX stage of the pipelined MIPS core.
- Driven by the decoder's Start, MDUOp, HIWrite and LOWrite controls.
- Provides Busy to the hazard unit, which stalls any MD-class instruction while an operation is in flight.
- Successor to the fixed-latency version: width and latencies are configurable, EX-stage cancellation is supported, and an optional accumulate mode is available.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  — clock; rising edge.
- reset  in  1  — asynchronous, active-low reset.
- Start  in  1  — begin an operation selected by MDUOp.
- MDUOp  in  2  — 00 multu, 01 mult, 10 divu, 11 div.
- Acc  in  1  — accumulate-mode select; only meaningful with MDU_MADD_EN.
- Sub  in  1  — accumulate subtract select; only meaningful with MDU_MADD_EN.
- HIWrite  in  1  — mthi: HI <= A.
- LOWrite  in  1  — mtlo: LO <= A.
- Flush  in  1  — exception or interrupt in the current EX instruction; cancels this cycle's request.
- A  in  WIDTH  — rs operand, forwarded.
- B  in  WIDTH  — rt operand, forwarded.
- Busy  out  1  — operation in flight; registered.
- HI  out  WIDTH  — HI register.
- LO  out  WIDTH  — LO register.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, Busy=0, HI=0, LO=0, operand and result latches 0.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; counter width is clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE → RUN: on an edge with Start=1 and Flush=0.
  - Latch the computed 2·WIDTH result.
  - Load counter with MULT_CYCLES for MDUOp[1]=0, DIV_CYCLES for MDUOp[1]=1.
- In RUN, each edge decrements the counter. On the edge where counter==1:
  - HI/LO <= latched result.
  - State returns to IDLE.
- Timing: Busy is high for exactly N cycles after the Start edge. New HI/LO values are visible the cycle Busy falls.
- mult: signed WIDTH×WIDTH to 2·WIDTH; HI = upper half, LO = lower half.
- multu: unsigned WIDTH×WIDTH to 2·WIDTH; HI = upper half, LO = lower half.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- div (signed): LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Special case: MIN/−1 gives LO = MIN, HI = 0.
- Divide by zero (B=0): the operation runs the full DIV_CYCLES, but HI and LO are left unchanged.
- HIWrite/LOWrite:
  - Take effect on the next edge, only in IDLE and only with Flush=0.
  - Both may be asserted together.
  - Ignored in RUN.
- Start in RUN: ignored; the hazard unit guarantees this does not occur. No error is flagged.
- Start together with HIWrite or LOWrite in the same cycle: Start wins and the write is dropped (decoder never produces this).
- Flush=1 masks Start, HIWrite and LOWrite in the same cycle. An operation already in RUN is not cancelled: it belongs to an older, committed instruction.
- Reset mid-operation aborts immediately to the reset values.
- Operand changes after the Start edge have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Start with Acc=1 performs madd/maddu (MDUOp 01/00) or msub/msubu (Sub=1).
  - Result = {HI,LO} ± product, modulo 2^(2·WIDTH).
  - {HI,LO} is sampled at the completion edge, not at Start.
  - Latency is MULT_CYCLES.
  - Acc=1 with a divide MDUOp is treated as Acc=0.
- Not defined: Acc and Sub are ignored; the unit behaves as plain mult/div.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (−2), B=3, default params → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu A=100, B=7 → Busy high 10 cycles; HI=2, LO=14.
- div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div by 0 after mthi 0x1234 and mtlo 0x5678 → Busy high 10 cycles; HI/LO remain 0x1234/0x5678.
- Start with Flush=1 → Busy stays 0 and HI/LO unchanged. Then mthi during RUN → ignored. Then reset pulse at cycle 3 of a mult → Busy=0, HI=LO=0 immediately.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0. Then msub A=1, B=2 → HI=0, LO=0xFFFFFFFE.
